uart_rx_fifo: RTL and testbench

Parametrised receive-side FIFO between the UART receiver deserialiser and the host/memory interface. It buffers received words together with a per-word line-error tag (framing/parity). Full/empty detection is exact (extra pointer wrap bit), and it provides an occupancy count, an almost-full threshold, a sticky overflow flag and a synchronous flush. Read data is registered and comes back with a `rd_valid` strobe.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_fifo_mem.sv | 34 +++
 rtl/uart_rx_fifo.sv | 133 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receive path.
//   UART_DATA_W          : width of a received UART word
//   UART_RX_FIFO_DEPTH   : default entry count of the receive FIFO
//   uart_rx_entry_t      : one stored word with its line-error tag
package uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int UART_RX_FIFO_DEPTH = 16;

  typedef struct packed {
    logic                   err;
    logic [UART_DATA_W-1:0] data;
  } uart_rx_entry_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem
// Storage array for the receive FIFO. Writes are synchronous; reads are
// combinational from the addressed entry. The array has no reset.
// Ports:
//   i_clk      : clock
//   i_wr_en    : write strobe
//   i_wr_addr  : write index
//   i_wr_data  : word written at i_wr_addr
//   i_rd_addr  : read index
//   o_rd_data  : contents of entry i_rd_addr
module uart_fifo_mem #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive-side FIFO between the UART deserialiser and the host. Each entry
// holds a word plus its framing/parity error tag. Read data is registered
// and qualified by a one-cycle o_rd_valid strobe.
// Ports:
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_flush             : synchronous clear of pointers, count and overflow
//   i_wr_en/data/err    : write request, word and error tag
//   i_rd_en             : read request
//   o_rd_data/err/valid : registered read word, its tag, and valid strobe
//   o_full, o_empty     : occupancy == DEPTH / == 0
//   o_almost_full       : occupancy >= AF_THRESH
//   o_count             : occupancy
//   o_overflow          : sticky, a write was dropped; cleared by i_ovf_clr
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W    = UART_DATA_W,
  parameter int DEPTH     = UART_RX_FIFO_DEPTH,
  parameter int AF_THRESH = DEPTH - 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_wr_en,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic                     i_wr_err,
  input  logic                     i_rd_en,
  output logic [DATA_W-1:0]        o_rd_data,
  output logic                     o_rd_err,
  output logic                     o_rd_valid,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_almost_full,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  input  logic                     i_ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE    = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] AF_LVL = AF_THRESH[AW:0];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_overflow;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_err;
  logic              r_rd_valid;

  logic              w_full;
  logic              w_empty;
  logic              w_rd_accept;
  logic              w_wr_accept;
  logic              w_ovf_set;
  logic [DATA_W:0]   w_rd_entry;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // Flush outranks both ports, so it suppresses both accepts here. A read
  // on an empty FIFO is ignored even if a write arrives in the same cycle.
  assign w_rd_accept = i_rd_en & ~w_empty & ~i_flush;
  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign w_wr_accept = i_wr_en & ~i_flush & (~w_full | w_rd_accept);
  assign w_ovf_set   = i_wr_en & ~i_flush & w_full & ~w_rd_accept;

  uart_fifo_mem #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk     (i_clk),
    .i_wr_en   (w_wr_accept),
    .i_wr_addr (r_wr_ptr[AW-1:0]),
    .i_wr_data ({i_wr_err, i_wr_data}),
    .i_rd_addr (r_rd_ptr[AW-1:0]),
    .o_rd_data (w_rd_entry)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_rd_data  <= '0;
      r_rd_err   <= 1'b0;
      r_rd_valid <= 1'b0;
    end else if (i_flush) begin
      // Storage and the last read word are deliberately left untouched.
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_accept;
      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + ONE;
      end
      if (w_rd_accept) begin
        r_rd_ptr  <= r_rd_ptr + ONE;
        r_rd_data <= w_rd_entry[DATA_W-1:0];
        r_rd_err  <= w_rd_entry[DATA_W];
      end
      case ({w_wr_accept, w_rd_accept})
        2'b10:   r_count <= r_count + ONE;
        2'b01:   r_count <= r_count - ONE;
        default: r_count <= r_count;
      endcase
      // Setting wins over a simultaneous clear so a drop is never missed.
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (i_ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign o_rd_data     = r_rd_data;
  assign o_rd_err      = r_rd_err;
  assign o_rd_valid    = r_rd_valid;
  assign o_full        = w_full;
  assign o_empty       = w_empty;
  assign o_almost_full = (r_count >= AF_LVL);
  assign o_count       = r_count;
  assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
// Directed bench for uart_rx_fifo with DEPTH=4, AF_THRESH=3. A table of
// one-cycle vectors gives the inputs for each cycle and the outputs expected
// just after that cycle's rising edge; a hand-written sequence covers the
// asynchronous reset in the middle of a read.
module tb_uart_rx_fifo;

  localparam int DEPTH = 4;
  localparam int AF    = 3;

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       we;
    logic       rd;
    logic       fl;
    logic       oc;
    logic       expValid;
    logic [7:0] expData;
    logic       expErr;
    logic [2:0] expCount;
    logic       expFull;
    logic       expEmpty;
    logic       expAf;
    logic       expOvf;
  } vec_t;

  logic       clock;
  logic       reset;
  logic       flush;
  logic       wrEn;
  logic [7:0] wrData;
  logic       wrErr;
  logic       rdEn;
  logic       ovfClr;
  logic [7:0] rdData;
  logic       rdErr;
  logic       rdValid;
  logic       full;
  logic       empty;
  logic       almostFull;
  logic [2:0] count;
  logic       overflow;

  int   checks;
  int   errors;
  vec_t vecs[$];

  uart_rx_fifo #(
    .DATA_W    (8),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF)
  ) dut (
    .i_clk         (clock),
    .i_rst         (reset),
    .i_flush       (flush),
    .i_wr_en       (wrEn),
    .i_wr_data     (wrData),
    .i_wr_err      (wrErr),
    .i_rd_en       (rdEn),
    .o_rd_data     (rdData),
    .o_rd_err      (rdErr),
    .o_rd_valid    (rdValid),
    .o_full        (full),
    .o_empty       (empty),
    .o_almost_full (almostFull),
    .o_count       (count),
    .o_overflow    (overflow),
    .i_ovf_clr     (ovfClr)
  );

  // Free-running 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Records one vector; the flag expectations follow from the expected count.
  task automatic addVec(input logic wr, input logic [7:0] wd, input logic we,
                        input logic rd, input logic fl, input logic oc,
                        input logic ev, input logic [7:0] ed, input logic ee,
                        input int ec, input logic eo);
    vec_t v;
    v.wr = wr; v.wd = wd; v.we = we; v.rd = rd; v.fl = fl; v.oc = oc;
    v.expValid = ev; v.expData = ed; v.expErr = ee;
    v.expCount = 3'(ec);
    v.expFull  = (ec == DEPTH);
    v.expEmpty = (ec == 0);
    v.expAf    = (ec >= AF);
    v.expOvf   = eo;
    vecs.push_back(v);
  endtask

  // One comparison; prints a FAIL line when actual differs from expected.
  task automatic compareOne(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one vector's inputs, starting at a falling edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clock);
    wrEn   = v.wr;
    wrData = v.wd;
    wrErr  = v.we;
    rdEn   = v.rd;
    flush  = v.fl;
    ovfClr = v.oc;
    @(posedge clock);
    #1;
  endtask

  // Compares every output against one vector's expectations.
  task automatic checkOutput(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    compareOne({tag, ".rd_valid"},    32'(rdValid),    32'(v.expValid));
    compareOne({tag, ".rd_data"},     32'(rdData),     32'(v.expData));
    compareOne({tag, ".rd_err"},      32'(rdErr),      32'(v.expErr));
    compareOne({tag, ".count"},       32'(count),      32'(v.expCount));
    compareOne({tag, ".full"},        32'(full),       32'(v.expFull));
    compareOne({tag, ".empty"},       32'(empty),      32'(v.expEmpty));
    compareOne({tag, ".almost_full"}, 32'(almostFull), 32'(v.expAf));
    compareOne({tag, ".overflow"},    32'(overflow),   32'(v.expOvf));
  endtask

  initial begin
    logic [7:0] prevData;
    logic       prevErr;
    checks = 0;
    errors = 0;

    // Basic write three, read three, then reads while empty.
    addVec(1, 8'h11, 0, 0, 0, 0,  0, 8'h00, 0, 1, 0);
    addVec(1, 8'h22, 1, 0, 0, 0,  0, 8'h00, 0, 2, 0);
    addVec(1, 8'h33, 0, 0, 0, 0,  0, 8'h00, 0, 3, 0);
    addVec(0, 8'h00, 0, 1, 0, 0,  1, 8'h11, 0, 2, 0);
    addVec(0, 8'h00, 0, 1, 0, 0,  1, 8'h22, 1, 1, 0);
    addVec(0, 8'h00, 0, 1, 0, 0,  1, 8'h33, 0, 0, 0);
    addVec(0, 8'h00, 0, 0, 0, 0,  0, 8'h33, 0, 0, 0);
    addVec(0, 8'h00, 0, 1, 0, 0,  0, 8'h33, 0, 0, 0);

    // Fill, drop a fifth write, drain, then clear overflow.
    addVec(1, 8'h41, 0, 0, 0, 0,  0, 8'h33, 0, 1, 0);
    addVec(1, 8'h42, 1, 0, 0, 0,  0, 8'h33, 0, 2, 0);
    addVec(1, 8'h43, 0, 0, 0, 0,  0, 8'h33, 0, 3, 0);
    addVec(1, 8'h44, 1, 0, 0, 0,  0, 8'h33, 0, 4, 0);
    addVec(1, 8'h55, 0, 0, 0, 0,  0, 8'h33, 0, 4, 1);
    addVec(0, 8'h00, 0, 1, 0, 0,  1, 8'h41, 0, 3, 1);
    addVec(0, 8'h00, 0, 1, 0, 0,  1, 8'h42, 1, 2, 1);
    addVec(0, 8'h00, 0, 1, 0, 0,  1, 8'h43, 0, 1, 1);
    addVec(0, 8'h00, 0, 1, 0, 0,  1, 8'h44, 1, 0, 1);
    addVec(0, 8'h00, 0, 0, 0, 1,  0, 8'h44, 1, 0, 0);

    // Simultaneous read and write while full.
    addVec(1, 8'h61, 0, 0, 0, 0,  0, 8'h44, 1, 1, 0);
    addVec(1, 8'h62, 0, 0, 0, 0,  0, 8'h44, 1, 2, 0);
    addVec(1, 8'h63, 0, 0, 0, 0,  0, 8'h44, 1, 3, 0);
    addVec(1, 8'h64, 0, 0, 0, 0,  0, 8'h44, 1, 4, 0);
    addVec(1, 8'hA5, 1, 1, 0, 0,  1, 8'h61, 0, 4, 0);
    addVec(0, 8'h00, 0, 1, 0, 0,  1, 8'h62, 0, 3, 0);
    addVec(0, 8'h00, 0, 1, 0, 0,  1, 8'h63, 0, 2, 0);
    addVec(0, 8'h00, 0, 1, 0, 0,  1, 8'h64, 0, 1, 0);
    addVec(0, 8'h00, 0, 1, 0, 0,  1, 8'hA5, 1, 0, 0);

    // Simultaneous read and write while empty: no fall-through.
    addVec(1, 8'h3C, 0, 1, 0, 0,  0, 8'hA5, 1, 1, 0);
    addVec(0, 8'h00, 0, 1, 0, 0,  1, 8'h3C, 0, 0, 0);

    // Ten write/read pairs walking the pointers across the wrap twice.
    prevData = 8'h3C;
    prevErr  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      addVec(1, 8'(i), i[0], 0, 0, 0,  0, prevData, prevErr, 1, 0);
      addVec(0, 8'h00, 0,    1, 0, 0,  1, 8'(i),    i[0],    0, 0);
      prevData = 8'(i);
      prevErr  = i[0];
    end

    // Three words held with overflow set, then flush with a write.
    addVec(1, 8'h71, 0, 0, 0, 0,  0, 8'h09, 1, 1, 0);
    addVec(1, 8'h72, 0, 0, 0, 0,  0, 8'h09, 1, 2, 0);
    addVec(1, 8'h73, 0, 0, 0, 0,  0, 8'h09, 1, 3, 0);
    addVec(1, 8'h74, 0, 0, 0, 0,  0, 8'h09, 1, 4, 0);
    addVec(1, 8'h75, 0, 0, 0, 0,  0, 8'h09, 1, 4, 1);
    addVec(0, 8'h00, 0, 1, 0, 0,  1, 8'h71, 0, 3, 1);
    addVec(1, 8'h99, 1, 0, 1, 0,  0, 8'h71, 0, 0, 0);
    addVec(0, 8'h00, 0, 0, 0, 0,  0, 8'h71, 0, 0, 0);
    addVec(1, 8'h81, 1, 0, 0, 0,  0, 8'h71, 0, 1, 0);
    addVec(0, 8'h00, 0, 1, 0, 0,  1, 8'h81, 1, 0, 0);

    // ovf_clr together with a dropped write: overflow stays set.
    addVec(1, 8'h91, 0, 0, 0, 0,  0, 8'h81, 1, 1, 0);
    addVec(1, 8'h92, 0, 0, 0, 0,  0, 8'h81, 1, 2, 0);
    addVec(1, 8'h93, 0, 0, 0, 0,  0, 8'h81, 1, 3, 0);
    addVec(1, 8'h94, 0, 0, 0, 0,  0, 8'h81, 1, 4, 0);
    addVec(1, 8'h95, 0, 0, 0, 1,  0, 8'h81, 1, 4, 1);
    addVec(0, 8'h00, 0, 0, 0, 1,  0, 8'h81, 1, 4, 0);
    // Flush beats a read in the same cycle.
    addVec(0, 8'h00, 0, 1, 1, 0,  0, 8'h81, 1, 0, 0);
    addVec(0, 8'h00, 0, 1, 0, 0,  0, 8'h81, 1, 0, 0);

    // Reset state.
    reset = 1'b1; flush = 1'b0; wrEn = 1'b0; wrData = 8'h00;
    wrErr = 1'b0; rdEn = 1'b0; ovfClr = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    compareOne("reset.rd_valid",    32'(rdValid),    32'd0);
    compareOne("reset.rd_data",     32'(rdData),     32'd0);
    compareOne("reset.rd_err",      32'(rdErr),      32'd0);
    compareOne("reset.count",       32'(count),      32'd0);
    compareOne("reset.full",        32'(full),       32'd0);
    compareOne("reset.empty",       32'(empty),      32'd1);
    compareOne("reset.almost_full", 32'(almostFull), 32'd0);
    compareOne("reset.overflow",    32'(overflow),   32'd0);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i]);
    end

    // Asynchronous reset right after a read was accepted.
    @(negedge clock);
    wrEn = 1'b1; wrData = 8'hC1; wrErr = 1'b1; rdEn = 1'b0; flush = 1'b0; ovfClr = 1'b0;
    @(negedge clock);
    wrEn = 1'b0; rdEn = 1'b1;
    @(posedge clock);
    #1;
    compareOne("arst.pre_valid", 32'(rdValid), 32'd1);
    compareOne("arst.pre_data",  32'(rdData),  32'hC1);
    #1;
    reset = 1'b1;
    #1;
    compareOne("arst.rd_valid", 32'(rdValid), 32'd0);
    compareOne("arst.rd_data",  32'(rdData),  32'd0);
    compareOne("arst.rd_err",   32'(rdErr),   32'd0);
    compareOne("arst.count",    32'(count),   32'd0);
    compareOne("arst.empty",    32'(empty),   32'd1);
    @(negedge clock);
    rdEn  = 1'b0;
    reset = 1'b0;
    @(posedge clock);
    #1;
    compareOne("arst.post_valid", 32'(rdValid), 32'd0);
    compareOne("arst.post_empty", 32'(empty),   32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
